// File: rtl/rll_pkg.sv
// Shared types and constants for the RLL frame scheduler and its slot timer.
package rll_pkg;

  localparam int unsigned MAX_BYTES  = 16;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned BYTE_BITS  = 8;
  localparam int unsigned PHASE_W    = 1;
  localparam int unsigned SLOT_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_PAY,
    ST_FLUSH,
    ST_GAP
  } state_t;

  // A frame request is honoured only for 1..MAX_BYTES payload bytes.
  function automatic logic len_ok(input logic [LEN_W-1:0] l);
    return (l != '0) && (l <= LEN_W'(MAX_BYTES));
  endfunction

endpackage

// File: rtl/rll_slot_timer.sv
// Two-cycle bit-slot timer: phase toggle plus a loadable slot down-counter.
module rll_slot_timer
  import rll_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [SLOT_CNT_W-1:0] load_val,
  output logic [SLOT_CNT_W-1:0] cnt,
  output logic                  slot_start,
  output logic                  slot_last
);

  logic [PHASE_W-1:0] phase;

  // load restarts at phase 0 with load_val+1 slots remaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
      cnt   <= '0;
    end else if (load) begin
      phase <= '0;
      cnt   <= load_val;
    end else begin
      phase <= phase + PHASE_W'(1);
      if ((phase != '0) && (cnt != '0)) begin
        cnt <= cnt - SLOT_CNT_W'(1);
      end
    end
  end

  assign slot_start = (phase == '0);
  assign slot_last  = (phase != '0) && (cnt == '0);

endmodule

// File: rtl/rll_frame_sched.sv
// Frame scheduler feeding a rate-1/2 RLL coder: preamble, payload, flush, gap.
module rll_frame_sched
  import rll_pkg::*;
#(
  parameter int unsigned              PREAMBLE_BITS = 8,
  parameter logic [PREAMBLE_BITS-1:0] PREAMBLE_PAT  = 8'hAA,
  parameter int unsigned              FLUSH_BITS    = 4,
  parameter int unsigned              GAP_SLOTS     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             coder_clr,
  output logic             coder_en,
  output logic             coder_bit,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [SLOT_CNT_W-1:0] PRE_LOAD   = SLOT_CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [SLOT_CNT_W-1:0] BYTE_LOAD  = SLOT_CNT_W'(BYTE_BITS - 1);
  localparam logic [SLOT_CNT_W-1:0] FLUSH_LOAD = SLOT_CNT_W'(FLUSH_BITS - 1);
  localparam logic [SLOT_CNT_W-1:0] GAP_LOAD   = SLOT_CNT_W'(GAP_SLOTS - 1);

  state_t                   state;
  logic [LEN_W-1:0]         bytes_left;
  logic [PREAMBLE_BITS-1:0] pre_sr;
  logic [7:0]               pay_sr;
  logic [SLOT_CNT_W-1:0]    cnt;
  logic                     slot_start;
  logic                     slot_last;
  logic                     load_c;
  logic [SLOT_CNT_W-1:0]    load_val_c;
  logic                     take_c;

  assign take_c = s_ready && s_valid;

  rll_slot_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load_c),
    .load_val   (load_val_c),
    .cnt        (cnt),
    .slot_start (slot_start),
    .slot_last  (slot_last)
  );

  // Timer reload: held in IDLE and the clear cycle, then once per state segment
  always_comb begin
    load_c     = 1'b0;
    load_val_c = PRE_LOAD;
    case (state)
      ST_IDLE: load_c = 1'b1;
      ST_PRE, ST_PAY: begin
        if (coder_clr) begin
          load_c = 1'b1;
        end else if (slot_last) begin
          load_c     = 1'b1;
          load_val_c = take_c ? BYTE_LOAD : FLUSH_LOAD;
        end
      end
      ST_FLUSH: begin
        if (slot_last) begin
          load_c     = 1'b1;
          load_val_c = GAP_LOAD;
        end
      end
      ST_GAP:  load_c = slot_last;
      default: load_c = 1'b1;
    endcase
  end

  // Outputs are computed one edge ahead so each is registered for its slot phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bytes_left <= '0;
      pre_sr     <= '0;
      pay_sr     <= '0;
      s_ready    <= 1'b0;
      coder_clr  <= 1'b0;
      coder_en   <= 1'b0;
      coder_bit  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      coder_clr <= 1'b0;
      coder_en  <= 1'b0;
      s_ready   <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE: begin
          coder_bit <= 1'b0;
          if (start && len_ok(len)) begin
            state      <= ST_PRE;
            coder_clr  <= 1'b1;
            busy       <= 1'b1;
            err        <= 1'b0;
            bytes_left <= len;
          end
        end
        ST_PRE, ST_PAY: begin
          if (coder_clr) begin
            coder_en  <= 1'b1;
            coder_bit <= PREAMBLE_PAT[PREAMBLE_BITS-1];
            pre_sr    <= PREAMBLE_PAT << 1;
          end else if (slot_start) begin
            s_ready <= (cnt == '0) && ((state == ST_PRE) || (bytes_left != '0));
          end else if (slot_last) begin
            coder_en <= 1'b1;
            if (take_c) begin
              state      <= ST_PAY;
              coder_bit  <= s_data[7];
              pay_sr     <= {s_data[6:0], 1'b0};
              bytes_left <= bytes_left - LEN_W'(1);
            end else begin
              // an unanswered fetch is an underrun; a missing fetch means payload done
              state     <= ST_FLUSH;
              coder_bit <= 1'b0;
              if (s_ready) begin
                err <= 1'b1;
              end
            end
          end else begin
            coder_en <= 1'b1;
            if (state == ST_PRE) begin
              coder_bit <= pre_sr[PREAMBLE_BITS-1];
              pre_sr    <= pre_sr << 1;
            end else begin
              coder_bit <= pay_sr[7];
              pay_sr    <= {pay_sr[6:0], 1'b0};
            end
          end
        end
        ST_FLUSH: begin
          coder_bit <= 1'b0;
          if (slot_last) begin
            state <= ST_GAP;
          end else if (!slot_start) begin
            coder_en <= 1'b1;
          end
        end
        ST_GAP: begin
          coder_bit <= 1'b0;
          if (slot_start) begin
            done <= (cnt == '0);
          end else if (slot_last) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rll_frame_sched.md
RLL_FRAME_SCHED -- requirements
Module: rll_frame_sched

Interface
REQ-001 Parameter PREAMBLE_BITS, default 8: number of preamble data bits sent before the payload.
REQ-002 Parameter PREAMBLE_PAT, default 8'hAA: preamble pattern, sent MSB first.
REQ-003 Parameter FLUSH_BITS, default 4: number of zero bits sent after the payload to terminate the last RLL word.
REQ-004 Parameter GAP_SLOTS, default 2: number of idle bit slots between frames.
REQ-005 Port list (name, direction, width, meaning):
- clk  in  1  single clock, rising edge; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  frame request; sampled only in IDLE.
- len  in  5  payload length in bytes, 1..16; sampled with start.
- s_data  in  8  payload byte.
- s_valid  in  1  payload byte valid.
- s_ready  out  1  byte accept strobe.
- coder_clr  out  1  one-cycle clear of the Coder state machine.
- coder_en  out  1  Coder bit strobe.
- coder_bit  out  1  data bit presented to the Coder (its inpt).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle end-of-frame pulse.
- err  out  1  sticky underrun flag.

Function
REQ-006 Bit slot is 2 clk cycles, tracked by a phase bit: phase 0 then phase 1; the Coder emits one code bit per cycle, giving code rate 1/2.
REQ-007 coder_en shall be high only in the phase-0 cycle of a slot; coder_bit shall be held stable for both cycles of the slot.
REQ-008 States: IDLE, PRE, PAY, FLUSH, GAP.
REQ-009 IDLE exit: start=1 with len in 1..16 goes to PRE next cycle; coder_clr=1 in that first PRE cycle, and phase restarts at 0 in the following cycle.
REQ-010 IDLE, invalid length: start=1 with len=0 or len>16 is ignored, and the block stays in IDLE.
REQ-011 PRE: sends PREAMBLE_PAT bits [PREAMBLE_BITS-1:0], MSB first, one bit per slot.
REQ-012 PRE byte fetch: s_ready=1 during phase 1 of the last preamble slot.
REQ-013 PAY: bytes are sent MSB first, with an 8-slot bit counter and a 5-bit byte counter.
REQ-014 PAY byte fetch: s_ready=1 during phase 1 of bit 0 of every byte except the last.
REQ-015 Handshake rule: a byte is accepted iff s_valid&&s_ready in that cycle; the accepted byte is sent starting at the next slot.
REQ-016 Underrun: s_ready=1 with s_valid=0 sets err=1 and goes to FLUSH; no further bytes are requested for that frame.
REQ-017 FLUSH: sends FLUSH_BITS zero bits, then goes to GAP.
REQ-018 GAP: coder_en=0 and coder_bit=0 for GAP_SLOTS slots; done=1 in the final GAP cycle; the next cycle is IDLE.
REQ-019 err clears only on reset or on acceptance of the next valid start.
REQ-020 start while busy is ignored (no queueing).
REQ-021 s_ready is never high outside the cycles defined in REQ-012 and REQ-014.
REQ-022 Frame length: a frame of len=N with no underrun shall last exactly 2*(PREAMBLE_BITS+8N+FLUSH_BITS+GAP_SLOTS)+1 cycles from start acceptance to the done cycle inclusive.

Reset
REQ-023 rst_n low asynchronously forces state=IDLE and clears phase and all counters.
REQ-024 Reset values: s_ready=0, coder_clr=0, coder_en=0, coder_bit=0, busy=0, done=0, err=0.
REQ-025 Reset mid-frame abandons the frame with no done pulse; the next frame begins with coder_clr.
REQ-026 rst_n deassertion has no output effect until the first clk edge.

Structure
REQ-027 Shared package rll_pkg: state enum, byte-count limit constant 16, and the slot-phase width.
REQ-028 Sub-module rll_slot_timer: phase toggle plus down-counter with load, producing slot_start and slot_last strobes; reused by all states.
REQ-029 The Coder is instantiated outside this block; coder_clr, coder_en and coder_bit drive it directly.

Verification
REQ-030 Single byte: len=1, s_data=8'hB4 always valid -> coder_bit sequence 1010_1010, 1011_0100, 0000; done at cycle 2*(8+8+4+2)+1=45; err=0.
REQ-031 Two bytes: len=2, bytes 8'h00 and 8'hFF -> exactly two s_ready/s_valid handshakes, 16 payload slots, and no coder_en during GAP.
REQ-032 Underrun: len=3, s_valid dropped before the 2nd byte -> err=1 at the 2nd fetch, 4 zero slots follow, done pulses, and err persists in IDLE.
REQ-033 Bad length: start with len=0, then start with len=17 -> busy stays 0 and coder_clr never pulses.
REQ-034 Reset mid-payload: rst_n low during PAY byte 1 -> all outputs 0 immediately; a new start then yields coder_clr and a full preamble.
REQ-035 start while busy: start pulses in PAY and GAP -> ignored; exactly one done pulse.
